// File: rtl/param_mod_counter.sv
// Modulo-N up/down counter with clear, clamped load, terminal-count strobe and registered wrap pulse.
// Define PARAM_MOD_COUNTER_SAT_EN to make the counter saturate at its bounds instead of wrapping.
module param_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MODULO    = 16,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] counter,
  output logic             tc,
  output logic             wrap
);

  localparam longint unsigned MOD_MAX = 64'd1 << WIDTH;
  localparam logic [WIDTH-1:0] TOP_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);

  if (MODULO < 2) begin : g_mod_too_small
    $error("param_mod_counter: MODULO must be at least 2");
  end
  if (64'(MODULO) > MOD_MAX) begin : g_mod_too_large
    $error("param_mod_counter: MODULO must not exceed 2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULO) begin : g_bad_reset_val
    $error("param_mod_counter: RESET_VAL must lie in 0..MODULO-1");
  end

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             wrap_q, wrap_d;
  logic             at_top, at_bot;

  assign at_top  = (counter_q == TOP_VAL);
  assign at_bot  = (counter_q == '0);
  // tc reflects the enabled bound regardless of clear/load on the same cycle.
  assign tc      = en & ((up & at_top) | (~up & at_bot));
  assign counter = counter_q;
  assign wrap    = wrap_q;

`ifdef PARAM_MOD_COUNTER_SAT_EN
  // Remembers that the bound was already hit so wrap pulses only once per hold.
  logic sat_q, sat_d;
`endif

  always_comb begin
    counter_d = counter_q;
    wrap_d    = 1'b0;
`ifdef PARAM_MOD_COUNTER_SAT_EN
    sat_d     = 1'b0;
`endif
    if (clear) begin
      counter_d = '0;
    end else if (load) begin
      counter_d = ({1'b0, load_val} >= MOD_EXT) ? TOP_VAL : load_val;
    end else if (en) begin
      if (tc) begin
`ifdef PARAM_MOD_COUNTER_SAT_EN
        counter_d = counter_q;
        wrap_d    = ~sat_q;
        sat_d     = 1'b1;
`else
        counter_d = up ? '0 : TOP_VAL;
        wrap_d    = 1'b1;
`endif
      end else begin
        counter_d = up ? (counter_q + 1'b1) : (counter_q - 1'b1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter_q <= RST_VAL;
      wrap_q    <= 1'b0;
    end else begin
      counter_q <= counter_d;
      wrap_q    <= wrap_d;
    end
  end

`ifdef PARAM_MOD_COUNTER_SAT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sat_q <= 1'b0;
    else        sat_q <= sat_d;
  end
`endif

endmodule

// File: tb/tb_param_mod_counter.sv
// Directed bench for param_mod_counter (WIDTH=4, MODULO=10): driver pushes expected observations,
// a negedge monitor pops and compares counter/tc/wrap.
module tb_param_mod_counter;

`ifdef PARAM_MOD_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       en, up, clear, load;
  logic [3:0] load_val;
  logic [3:0] counter;
  logic       tc, wrap;

  logic [5:0] exp_q[$];
  string      name_q[$];
  int         n_cmp;
  int         n_bad;

  param_mod_counter #(.WIDTH(4), .MODULO(10), .RESET_VAL(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .up       (up),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .counter  (counter),
    .tc       (tc),
    .wrap     (wrap)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [3:0] lv);
    en = e; up = u; clear = c; load = l; load_val = lv;
  endtask

  task automatic expect_now(input logic [3:0] cnt, input logic t, input logic w, input string nm);
    exp_q.push_back({cnt, t, w});
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic e, input logic u, input logic c, input logic l,
                     input logic [3:0] lv, input logic [3:0] cnt, input logic t,
                     input logic w, input string nm);
    drive(e, u, c, l, lv);
    expect_now(cnt, t, w, nm);
    tick();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [5:0] e;
    string      nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_cmp++;
      if ({counter, tc, wrap} !== e) begin
        n_bad++;
        $display("FAIL %s: got counter=%0d tc=%0b wrap=%0b, expected counter=%0d tc=%0b wrap=%0b",
                 nm, counter, tc, wrap, e[5:2], e[1], e[0]);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    drive(0, 1, 0, 0, 4'd0);
    tick();
    cyc(0, 1, 0, 0, 4'd0, 4'd0, 0, 0, "reset_state");
    reset = 1'b1;

    // Test 1: count up across the wrap.
    for (int i = 0; i < 12; i++) begin
      if (SAT) cyc(1, 1, 0, 0, 4'd0, (i > 9) ? 4'd9 : 4'(i), (i >= 9), (i == 10), "t1_up_sat");
      else     cyc(1, 1, 0, 0, 4'd0, 4'(i % 10), (i % 10 == 9), (i == 10), "t1_up_wrap");
    end

    // Test 2: reach 3 then count down through 0.
    cyc(0, 1, 0, 1, 4'd2, SAT ? 4'd9 : 4'd2, 0, 0, "t2_load2");
    cyc(1, 1, 0, 0, 4'd0, 4'd2, 0, 0, "t2_to3");
    cyc(1, 0, 0, 0, 4'd0, 4'd3, 0, 0, "t2_dn3");
    cyc(1, 0, 0, 0, 4'd0, 4'd2, 0, 0, "t2_dn2");
    cyc(1, 0, 0, 0, 4'd0, 4'd1, 0, 0, "t2_dn1");
    cyc(1, 0, 0, 0, 4'd0, 4'd0, 1, 0, "t2_dn0_tc");
    if (SAT) cyc(1, 0, 0, 0, 4'd0, 4'd0, 1, 1, "t2_sat_hold");
    else     cyc(1, 0, 0, 0, 4'd0, 4'd9, 0, 1, "t2_wrap9");

    // Test 3: clear beats load beats en; out-of-range load clamps.
    cyc(0, 0, 0, 1, 4'd5, SAT ? 4'd0 : 4'd8, 0, 0, "t3_load5");
    cyc(1, 1, 1, 1, 4'd7, 4'd5, 0, 0, "t3_clr_ld_en");
    cyc(0, 1, 0, 1, 4'd12, 4'd0, 0, 0, "t3_load12");
    cyc(1, 1, 1, 0, 4'd0, 4'd9, 1, 0, "t3_clamp_tc_clr");
    cyc(0, 1, 0, 1, 4'd4, 4'd0, 0, 0, "t3_after_clr");

    // Test 5: en low holds the count.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 4'd0, 4'd4, 0, 0, "t5_hold");
    cyc(1, 1, 0, 0, 4'd0, 4'd4, 0, 0, "t5_resume");
    cyc(1, 1, 0, 0, 4'd0, 4'd5, 0, 0, "t5_to5");

    // Test 4: async reset between edges at count 6.
    drive(0, 1, 0, 0, 4'd0);
    #2 reset = 1'b0;
    expect_now(4'd0, 0, 0, "t4_async_rst");
    tick();
    cyc(1, 1, 0, 0, 4'd0, 4'd0, 0, 0, "t4_rst_held");
    reset = 1'b1;

    // Async reset while wrap is high must drop wrap at once.
    cyc(0, 1, 0, 1, 4'd9, 4'd0, 0, 0, "t4b_load9");
    cyc(1, 1, 0, 0, 4'd0, 4'd9, 1, 0, "t4b_at9");
    drive(0, 1, 0, 0, 4'd0);
    #2 reset = 1'b0;
    expect_now(4'd0, 0, 0, "t4b_rst_wrap");
    tick();
    reset = 1'b1;

    // Test 6: run into the upper bound from 7, then reverse.
    cyc(0, 1, 0, 1, 4'd7, 4'd0, 0, 0, "t6_load7");
    cyc(1, 1, 0, 0, 4'd0, 4'd7, 0, 0, "t6_7");
    cyc(1, 1, 0, 0, 4'd0, 4'd8, 0, 0, "t6_8");
    cyc(1, 1, 0, 0, 4'd0, 4'd9, 1, 0, "t6_9");
    if (SAT) begin
      cyc(1, 1, 0, 0, 4'd0, 4'd9, 1, 1, "t6_hold_first");
      cyc(1, 1, 0, 0, 4'd0, 4'd9, 1, 0, "t6_hold2");
      cyc(1, 1, 0, 0, 4'd0, 4'd9, 1, 0, "t6_hold3");
      cyc(1, 0, 0, 0, 4'd0, 4'd9, 0, 0, "t6_reverse");
      cyc(0, 0, 0, 0, 4'd0, 4'd8, 0, 0, "t6_left_bound");
    end else begin
      cyc(1, 1, 0, 0, 4'd0, 4'd0, 0, 1, "t6_wrap0");
      cyc(1, 0, 0, 0, 4'd0, 4'd1, 0, 0, "t6_1");
      cyc(1, 0, 0, 0, 4'd0, 4'd0, 1, 0, "t6_dn0");
      cyc(0, 0, 0, 0, 4'd0, 4'd9, 0, 1, "t6_dnwrap");
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
